// File: rtl/ps2_joy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_joy_pkg
// Description : PS/2 set-2 scancodes, NES bit indices and key lookup.
// Revision    : 1.0
// ============================================================================
package ps2_joy_pkg;

  localparam logic [7:0] c_sc_ext   = 8'hE0;
  localparam logic [7:0] c_sc_brk   = 8'hF0;
  localparam logic [7:0] c_sc_pause = 8'hE1;

  localparam logic [7:0] c_sc_p1_a      = 8'h22;
  localparam logic [7:0] c_sc_p1_b      = 8'h1A;
  localparam logic [7:0] c_sc_p1_select = 8'h59;
  localparam logic [7:0] c_sc_p1_start  = 8'h5A;
  localparam logic [7:0] c_sc_p1_up     = 8'h75;
  localparam logic [7:0] c_sc_p1_down   = 8'h72;
  localparam logic [7:0] c_sc_p1_left   = 8'h6B;
  localparam logic [7:0] c_sc_p1_right  = 8'h74;

  localparam logic [7:0] c_sc_p2_a      = 8'h34;
  localparam logic [7:0] c_sc_p2_b      = 8'h2B;
  localparam logic [7:0] c_sc_p2_select = 8'h15;
  localparam logic [7:0] c_sc_p2_start  = 8'h1D;
  localparam logic [7:0] c_sc_p2_up     = 8'h43;
  localparam logic [7:0] c_sc_p2_down   = 8'h42;
  localparam logic [7:0] c_sc_p2_left   = 8'h3B;
  localparam logic [7:0] c_sc_p2_right  = 8'h4B;

  localparam logic [7:0] c_sc_pad1  = 8'h16;
  localparam logic [7:0] c_sc_pad2  = 8'h1E;
  localparam logic [7:0] c_sc_pad3  = 8'h26;
  localparam logic [7:0] c_sc_pad4  = 8'h25;
  localparam logic [7:0] c_sc_pad5  = 8'h2D;
  localparam logic [7:0] c_sc_pad6  = 8'h2C;
  localparam logic [7:0] c_sc_pad7  = 8'h35;
  localparam logic [7:0] c_sc_pad8  = 8'h3C;
  localparam logic [7:0] c_sc_pad9  = 8'h2A;
  localparam logic [7:0] c_sc_pad10 = 8'h32;
  localparam logic [7:0] c_sc_pad11 = 8'h31;
  localparam logic [7:0] c_sc_pad12 = 8'h3A;

  localparam logic [3:0] c_nes_a      = 4'd0;
  localparam logic [3:0] c_nes_b      = 4'd1;
  localparam logic [3:0] c_nes_select = 4'd2;
  localparam logic [3:0] c_nes_start  = 4'd3;
  localparam logic [3:0] c_nes_up     = 4'd4;
  localparam logic [3:0] c_nes_down   = 4'd5;
  localparam logic [3:0] c_nes_left   = 4'd6;
  localparam logic [3:0] c_nes_right  = 4'd7;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_JOY0 = 2'd1,
    TGT_JOY1 = 2'd2,
    TGT_PAD  = 2'd3
  } key_tgt_e;

  typedef struct packed {
    key_tgt_e   tgt;
    logic [3:0] idx;
  } key_map_t;

  // The ext prefix is part of the key identity: {ext, code} must match exactly.
  function automatic key_map_t lookup_key(input logic ext, input logic [7:0] code);
    key_map_t m;
    m = '{TGT_NONE, 4'd0};
    case ({ext, code})
      {1'b0, c_sc_p1_a}:      m = '{TGT_JOY0, c_nes_a};
      {1'b0, c_sc_p1_b}:      m = '{TGT_JOY0, c_nes_b};
      {1'b0, c_sc_p1_select}: m = '{TGT_JOY0, c_nes_select};
      {1'b0, c_sc_p1_start}:  m = '{TGT_JOY0, c_nes_start};
      {1'b1, c_sc_p1_up}:     m = '{TGT_JOY0, c_nes_up};
      {1'b1, c_sc_p1_down}:   m = '{TGT_JOY0, c_nes_down};
      {1'b1, c_sc_p1_left}:   m = '{TGT_JOY0, c_nes_left};
      {1'b1, c_sc_p1_right}:  m = '{TGT_JOY0, c_nes_right};
      {1'b0, c_sc_p2_a}:      m = '{TGT_JOY1, c_nes_a};
      {1'b0, c_sc_p2_b}:      m = '{TGT_JOY1, c_nes_b};
      {1'b0, c_sc_p2_select}: m = '{TGT_JOY1, c_nes_select};
      {1'b0, c_sc_p2_start}:  m = '{TGT_JOY1, c_nes_start};
      {1'b0, c_sc_p2_up}:     m = '{TGT_JOY1, c_nes_up};
      {1'b0, c_sc_p2_down}:   m = '{TGT_JOY1, c_nes_down};
      {1'b0, c_sc_p2_left}:   m = '{TGT_JOY1, c_nes_left};
      {1'b0, c_sc_p2_right}:  m = '{TGT_JOY1, c_nes_right};
      {1'b0, c_sc_pad1}:      m = '{TGT_PAD, 4'd0};
      {1'b0, c_sc_pad2}:      m = '{TGT_PAD, 4'd1};
      {1'b0, c_sc_pad3}:      m = '{TGT_PAD, 4'd2};
      {1'b0, c_sc_pad4}:      m = '{TGT_PAD, 4'd3};
      {1'b0, c_sc_pad5}:      m = '{TGT_PAD, 4'd4};
      {1'b0, c_sc_pad6}:      m = '{TGT_PAD, 4'd5};
      {1'b0, c_sc_pad7}:      m = '{TGT_PAD, 4'd6};
      {1'b0, c_sc_pad8}:      m = '{TGT_PAD, 4'd7};
      {1'b0, c_sc_pad9}:      m = '{TGT_PAD, 4'd8};
      {1'b0, c_sc_pad10}:     m = '{TGT_PAD, 4'd9};
      {1'b0, c_sc_pad11}:     m = '{TGT_PAD, 4'd10};
      {1'b0, c_sc_pad12}:     m = '{TGT_PAD, 4'd11};
      default:                m = '{TGT_NONE, 4'd0};
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_joypad_decoder_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 synchronizer, clock glitch filter, frame receiver, timeout.
// Revision    : 1.0
// ============================================================================
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLK_50M,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err
);

  localparam int c_FILT_W = $clog2(FILTER_LEN + 1);
  localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]          r_clk_sync;
  logic [1:0]          r_data_sync;
  logic                r_filt_level;
  logic [c_FILT_W-1:0] r_filt_cnt;
  logic                r_fall;
  logic [3:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                r_parity;
  logic [c_TO_W-1:0]   r_to_cnt;

  logic w_filt_flip;
  logic w_data;

  assign w_filt_flip = (r_clk_sync[1] != r_filt_level) &&
                       (r_filt_cnt == c_FILT_W'(FILTER_LEN - 1));
  assign w_data      = r_data_sync[1];

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
    end
  end

  // Level only changes after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      r_filt_level <= 1'b1;
      r_filt_cnt   <= '0;
      r_fall       <= 1'b0;
    end else begin
      r_fall <= w_filt_flip && r_filt_level;
      if (r_clk_sync[1] == r_filt_level) begin
        r_filt_cnt <= '0;
      end else if (w_filt_flip) begin
        r_filt_level <= r_clk_sync[1];
        r_filt_cnt   <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      r_bit_cnt    <= 4'd0;
      r_shift      <= 8'd0;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      o_byte_valid <= 1'b0;
      o_byte       <= 8'd0;
      o_frame_err  <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      if (r_fall) begin
        r_to_cnt <= '0;
        if (r_bit_cnt == 4'd0) begin
          if (!w_data) r_bit_cnt <= 4'd1;
        end else if (r_bit_cnt <= 4'd8) begin
          r_shift   <= {w_data, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end else if (r_bit_cnt == 4'd9) begin
          r_parity  <= w_data;
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end else begin
          r_bit_cnt <= 4'd0;
          if (w_data && (^{r_shift, r_parity})) begin
            o_byte_valid <= 1'b1;
            o_byte       <= r_shift;
          end else begin
            o_frame_err <= 1'b1;
          end
        end
      end else if (r_bit_cnt != 4'd0) begin
        // A stalled partial frame is dropped silently.
        if (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1)) begin
          r_bit_cnt <= 4'd0;
          r_shift   <= 8'd0;
          r_to_cnt  <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_joypad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_joypad_decoder
// Description : Maps PS/2 keyboard scancodes to two NES pads and a power pad.
// Revision    : 1.0
// ============================================================================
module ps2_joypad_decoder
  import ps2_joy_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 8
) (
  input  logic        CLK_50M,
  input  logic        reset,
  input  logic        ps2_kbd_clk,
  input  logic        ps2_kbd_data,
  output logic [7:0]  joystick_0,
  output logic [7:0]  joystick_1,
  output logic [11:0] powerpad,
  output logic        frame_err
);

  logic       w_byte_valid;
  logic [7:0] w_byte;
  logic       w_frame_err;
  key_map_t   w_key;

  logic        r_ext;
  logic        r_brk;
  logic [7:0]  r_joy0;
  logic [7:0]  r_joy1;
  logic [11:0] r_pad;

  ps2_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .FILTER_LEN     (FILTER_LEN)
  ) u_rx (
    .CLK_50M      (CLK_50M),
    .reset        (reset),
    .i_ps2_clk    (ps2_kbd_clk),
    .i_ps2_data   (ps2_kbd_data),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_frame_err  (w_frame_err)
  );

  assign w_key = lookup_key(r_ext, w_byte);

  // Prefix bytes only arm flags; any other byte consumes and clears them.
  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_joy0 <= 8'd0;
      r_joy1 <= 8'd0;
      r_pad  <= 12'd0;
    end else if (w_frame_err) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_byte_valid) begin
      if (w_byte == c_sc_ext) begin
        r_ext <= 1'b1;
      end else if (w_byte == c_sc_brk) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        case (w_key.tgt)
          TGT_JOY0: r_joy0[w_key.idx[2:0]] <= !r_brk;
          TGT_JOY1: r_joy1[w_key.idx[2:0]] <= !r_brk;
          TGT_PAD:  r_pad[w_key.idx]       <= !r_brk;
          default:  ;
        endcase
      end
    end
  end

  assign joystick_0 = r_joy0;
  assign joystick_1 = r_joy1;
  assign powerpad   = r_pad;
  assign frame_err  = w_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_joypad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_joypad_decoder
// Description : Self-checking bench: vector table, corner sequences, random frames.
// Revision    : 1.0
// ============================================================================
module tb_ps2_joypad_decoder;

  localparam int HALF = 12;

  logic        CLK_50M = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_kbd_clk = 1'b1;
  logic        ps2_kbd_data = 1'b1;
  logic [7:0]  joystick_0;
  logic [7:0]  joystick_1;
  logic [11:0] powerpad;
  logic        frame_err;

  ps2_joypad_decoder #(
    .TIMEOUT_CYCLES (50000),
    .FILTER_LEN     (8)
  ) dut (
    .CLK_50M      (CLK_50M),
    .reset        (reset),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data),
    .joystick_0   (joystick_0),
    .joystick_1   (joystick_1),
    .powerpad     (powerpad),
    .frame_err    (frame_err)
  );

  always #10 CLK_50M = ~CLK_50M;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int err_seen = 0;
  int stop_cyc = 0;
  int j0_chg_cyc = 0;
  logic [7:0] j0_prev = 8'd0;

  always @(posedge CLK_50M) cyc <= cyc + 1;

  always @(negedge CLK_50M) begin
    if (frame_err === 1'b1) err_seen = err_seen + 1;
    if (joystick_0 !== j0_prev) j0_chg_cyc = cyc;
    j0_prev = joystick_0;
  end

  // Reference model: key table lookup over {ext, code}
  logic [7:0] p1_codes [8] = '{8'h22, 8'h1A, 8'h59, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74};
  logic [7:0] p2_codes [8] = '{8'h34, 8'h2B, 8'h15, 8'h1D, 8'h43, 8'h42, 8'h3B, 8'h4B};
  logic [7:0] pd_codes [12] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2D, 8'h2C,
                                8'h35, 8'h3C, 8'h2A, 8'h32, 8'h31, 8'h3A};
  bit          m_ext, m_brk;
  logic [7:0]  m_j0, m_j1;
  logic [11:0] m_pad;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_j0 = 8'd0; m_j1 = 8'd0; m_pad = 12'd0;
  endtask

  task automatic model_step(input logic [7:0] code, input int bad);
    if (bad != 0) begin
      m_ext = 0; m_brk = 0;
    end else if (code == 8'hE0) begin
      m_ext = 1;
    end else if (code == 8'hF0) begin
      m_brk = 1;
    end else begin
      for (int i = 0; i < 8; i++)
        if (code == p1_codes[i] && m_ext == (i >= 4)) m_j0[i] = !m_brk;
      for (int i = 0; i < 8; i++)
        if (!m_ext && code == p2_codes[i]) m_j1[i] = !m_brk;
      for (int i = 0; i < 12; i++)
        if (!m_ext && code == pd_codes[i]) m_pad[i] = !m_brk;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      repeat (HALF / 2) @(posedge CLK_50M);
      ps2_kbd_data = bits[i];
      repeat (HALF - HALF / 2) @(posedge CLK_50M);
      ps2_kbd_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(posedge CLK_50M);
      ps2_kbd_clk = 1'b1;
    end
  endtask

  // bad: 0 = good frame, 1 = wrong parity, 2 = stop bit 0
  task automatic send_frame(input logic [7:0] b, input int bad);
    logic par;
    logic stp;
    par = ~(^b);
    if (bad == 1) par = ~par;
    stp = (bad == 2) ? 1'b0 : 1'b1;
    send_bits({stp, par, b, 1'b0}, 11);
    ps2_kbd_data = 1'b1;
    repeat (30) @(posedge CLK_50M);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge CLK_50M);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_outs(input string name, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [11:0] ep, input int eerr, input int err0);
    @(negedge CLK_50M);
    chk({name, ".joystick_0"}, 32'(joystick_0), 32'(e0));
    chk({name, ".joystick_1"}, 32'(joystick_1), 32'(e1));
    chk({name, ".powerpad"}, 32'(powerpad), 32'(ep));
    chk({name, ".frame_err_cycles"}, 32'(err_seen - err0), 32'(eerr));
  endtask

  typedef struct {
    logic [7:0]  code;
    int          bad;
    logic [7:0]  j0;
    logic [7:0]  j1;
    logic [11:0] pad;
    int          err;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vt [NVEC];

  initial begin
    int e0;
    int lat;
    int r;
    int bad;
    logic [7:0] code;

    vt[0]  = '{8'h22, 0, 8'h01, 8'h00, 12'h000, 0};
    vt[1]  = '{8'hF0, 0, 8'h01, 8'h00, 12'h000, 0};
    vt[2]  = '{8'h22, 0, 8'h00, 8'h00, 12'h000, 0};
    vt[3]  = '{8'hE0, 0, 8'h00, 8'h00, 12'h000, 0};
    vt[4]  = '{8'h75, 0, 8'h10, 8'h00, 12'h000, 0};
    vt[5]  = '{8'h75, 0, 8'h10, 8'h00, 12'h000, 0};
    vt[6]  = '{8'hE0, 0, 8'h10, 8'h00, 12'h000, 0};
    vt[7]  = '{8'hF0, 0, 8'h10, 8'h00, 12'h000, 0};
    vt[8]  = '{8'h75, 0, 8'h00, 8'h00, 12'h000, 0};
    vt[9]  = '{8'h22, 1, 8'h00, 8'h00, 12'h000, 1};
    vt[10] = '{8'h1A, 0, 8'h02, 8'h00, 12'h000, 0};
    vt[11] = '{8'h34, 0, 8'h02, 8'h01, 12'h000, 0};
    vt[12] = '{8'h2B, 0, 8'h02, 8'h03, 12'h000, 0};
    vt[13] = '{8'h16, 0, 8'h02, 8'h03, 12'h001, 0};
    vt[14] = '{8'h3A, 0, 8'h02, 8'h03, 12'h801, 0};
    vt[15] = '{8'hE0, 0, 8'h02, 8'h03, 12'h801, 0};
    vt[16] = '{8'h22, 0, 8'h02, 8'h03, 12'h801, 0};
    vt[17] = '{8'h22, 0, 8'h03, 8'h03, 12'h801, 0};
    vt[18] = '{8'hE1, 0, 8'h03, 8'h03, 12'h801, 0};
    vt[19] = '{8'hF0, 0, 8'h03, 8'h03, 12'h801, 0};
    vt[20] = '{8'h22, 0, 8'h02, 8'h03, 12'h801, 0};
    vt[21] = '{8'hF0, 0, 8'h02, 8'h03, 12'h801, 0};
    vt[22] = '{8'h59, 0, 8'h02, 8'h03, 12'h801, 0};
    vt[23] = '{8'h22, 2, 8'h02, 8'h03, 12'h801, 1};
    vt[24] = '{8'hF0, 0, 8'h02, 8'h03, 12'h801, 0};
    vt[25] = '{8'h22, 1, 8'h02, 8'h03, 12'h801, 1};
    vt[26] = '{8'h22, 0, 8'h03, 8'h03, 12'h801, 0};
    vt[27] = '{8'h22, 0, 8'h03, 8'h03, 12'h801, 0};

    do_reset();
    repeat (5) @(posedge CLK_50M);
    check_outs("reset", 8'h00, 8'h00, 12'h000, 0, err_seen);

    for (int i = 0; i < NVEC; i++) begin
      e0 = err_seen;
      send_frame(vt[i].code, vt[i].bad);
      check_outs($sformatf("vec%0d", i), vt[i].j0, vt[i].j1, vt[i].pad, vt[i].err, e0);
      if (i == 0) begin
        lat = j0_chg_cyc - stop_cyc;
        chk("stop_to_output_latency_in_range", 32'(lat >= 2 && lat <= 16), 32'd1);
      end
    end

    // Short low glitch on the PS/2 clock must not start a frame
    do_reset();
    ps2_kbd_data = 1'b0;
    ps2_kbd_clk = 1'b0;
    repeat (3) @(posedge CLK_50M);
    ps2_kbd_clk = 1'b1;
    repeat (40) @(posedge CLK_50M);
    e0 = err_seen;
    send_frame(8'h34, 0);
    check_outs("glitch", 8'h00, 8'h01, 12'h000, 0, e0);

    // Partial frame abandoned after idle timeout
    do_reset();
    e0 = err_seen;
    send_bits(11'h7FE, 5);
    ps2_kbd_data = 1'b1;
    repeat (60000) @(posedge CLK_50M);
    send_frame(8'h16, 0);
    check_outs("timeout", 8'h00, 8'h00, 12'h001, 0, e0);

    // Reset clears a pending break prefix
    do_reset();
    send_frame(8'hF0, 0);
    do_reset();
    e0 = err_seen;
    send_frame(8'h22, 0);
    check_outs("brk_then_reset", 8'h01, 8'h00, 12'h000, 0, e0);
    do_reset();
    check_outs("reset_clears", 8'h00, 8'h00, 12'h000, 0, err_seen);

    // Reset in the middle of a frame drops it
    send_bits(11'h645, 6);
    do_reset();
    ps2_kbd_data = 1'b1;
    repeat (20) @(posedge CLK_50M);
    e0 = err_seen;
    send_frame(8'h1A, 0);
    check_outs("reset_midframe", 8'h02, 8'h00, 12'h000, 0, e0);

    // Randomized frames against the reference model
    do_reset();
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 1) code = 8'hE0;
      else if (r <= 3) code = 8'hF0;
      else if (r == 4) code = ($urandom_range(0, 1) == 0) ? 8'hE1 : 8'($urandom_range(0, 255));
      else begin
        r = $urandom_range(0, 27);
        if (r < 8) code = p1_codes[r];
        else if (r < 16) code = p2_codes[r - 8];
        else code = pd_codes[r - 16];
      end
      bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      e0 = err_seen;
      send_frame(code, bad);
      model_step(code, bad);
      check_outs($sformatf("rand%0d_%02h", n, code), m_j0, m_j1, m_pad, (bad != 0) ? 1 : 0, e0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_joypad_decoder.md
PS2_JOYPAD_DECODER -- requirements
Module: ps2_joypad_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, is the number of idle CLK_50M cycles (1 ms) after which a partial frame is abandoned.
REQ-002 Parameter FILTER_LEN, default 8, is the number of consecutive equal synchronized samples required to change the filtered PS/2 clock level.
REQ-003 Port CLK_50M, input, 1, system clock; reset is synchronous, active-high, on CLK_50M.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port ps2_kbd_clk, input, 1, raw PS/2 clock, asynchronous.
REQ-006 Port ps2_kbd_data, input, 1, raw PS/2 data, asynchronous.
REQ-007 Port joystick_0, output, 8, player-1 buttons in NES shift order: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
REQ-008 Port joystick_1, output, 8, player-2 buttons, same bit order.
REQ-009 Port powerpad, output, 12, power-pad pads 1..12 on bits [0]..[11].
REQ-010 Port frame_err, output, 1, single-cycle pulse on a rejected frame.

Function
REQ-011 Both inputs pass through a 2-FF synchronizer; the clock then passes through the FILTER_LEN glitch filter.
REQ-012 Bits are sampled on each falling edge of the filtered clock.
REQ-013 Frame format: start 0, 8 data bits LSB first, odd parity, stop 1; a 4-bit counter tracks bits 0..10.
REQ-014 A start bit of 1 is ignored and the counter stays at 0.
REQ-015 Accept: parity odd over data+parity and stop=1 gives a byte_valid pulse on the cycle after the stop-bit edge.
REQ-016 Reject: a parity or stop failure pulses frame_err in that same cycle, discards the byte, and clears the E0 and F0 flags.
REQ-017 Timeout: counter nonzero with no falling edge for TIMEOUT_CYCLES cycles sets the counter to 0, discards partial data, and does not pulse frame_err.
REQ-018 Decoder byte 0xE0 sets the ext flag.
REQ-019 Decoder byte 0xF0 sets the brk flag.
REQ-020 Decoder byte 0xE1 and any unmapped {ext,code} change no output and clear both flags.
REQ-021 Decoder mapped {ext,code}: the target bit is written with !brk and both flags are cleared.
REQ-022 Outputs update on the cycle after byte_valid, 2 cycles after the stop-bit edge is detected.
REQ-023 Player-1 map (set 2): A=22, B=1A, Select=59, Start=5A, Up=E0 75, Down=E0 72, Left=E0 6B, Right=E0 74.
REQ-024 Player-2 map: A=34, B=2B, Select=15, Start=1D, Up=43, Down=42, Left=3B, Right=4B.
REQ-025 Power-pad map, pads 1..12 in order: 16, 1E, 26, 25, 2D, 2C, 35, 3C, 2A, 32, 31, 3A.
REQ-026 The ext flag must match exactly: 75 without E0 does not map to Up, and E0 22 does not map to A.
REQ-027 Make repeats (typematic) are idempotent, and a break for an unpressed key leaves that bit 0.
REQ-028 Player-1 and player-2 bits are independent; simultaneous presses are held concurrently.

Reset
REQ-029 Reset clears joystick_0, joystick_1, powerpad, frame_err, the bit counter, the shift register, the timeout counter, and the ext/brk flags.
REQ-030 Reset sets filter state to filtered level 1 and counts to 0.
REQ-031 Reset mid-frame abandons the frame, and no byte_valid occurs for it.
REQ-032 Reset takes effect in the cycle it is sampled and overrides a coincident byte_valid.

Structure
REQ-033 Package ps2_joy_pkg holds the scancode constants (E0, F0, E1, every mapped code) and the NES bit-index constants.
REQ-034 Sub-module ps2_rx contains the synchronizer, filter, frame receiver and timeout; it outputs byte_valid, byte and frame_err.
REQ-035 The scancode decode and output registers are in ps2_joypad_decoder.

Verification
REQ-036 Frame 22 sets joystick_0=8'h01 two cycles after the stop edge; frames F0,22 then set joystick_0=8'h00.
REQ-037 Frames E0,75 set joystick_0[4]=1; frame 75 alone leaves joystick_0 unchanged.
REQ-038 Frame 22 with a bad parity bit pulses frame_err for 1 cycle with joystick_0 still 0; the next valid 1A sets joystick_0=8'h02.
REQ-039 Five bits followed by 60000 idle cycles abandon the frame; a full 16 then sets powerpad=12'h001 with no frame_err.
REQ-040 A 3-cycle low glitch on ps2_kbd_clk with FILTER_LEN=8 is ignored, and the following frame 34 sets joystick_1=8'h01.
REQ-041 Frame F0, then reset, then frame 22 gives joystick_0=8'h01; a further reset clears all outputs to 0.
